// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline widths, WB bit positions and MEM-stage FSM states.
package mem_wb_stage_pkg;
  localparam int XLEN = 64;
  localparam int REGW = 5;
  localparam int WBW = 2;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: doubleword data-memory request/ready bus.
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;
  logic req;
  logic we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic ready;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, input ready, rdata);
  modport slave(input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; any cycle without load inserts a bubble (WB cleared, data held).
module mem_wb_reg
  import mem_wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            load_rd,
  input  logic [WBW-1:0]  wb,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] rdata,
  input  logic [REGW-1:0] rd,
  output logic [WBW-1:0]  wb_out,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] rdata_out,
  output logic [REGW-1:0] rd_out
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wb_out <= '0;
      alu_out <= '0;
      rdata_out <= '0;
      rd_out <= '0;
    end else begin
      wb_out <= load ? wb : '0;
      if (load) begin
        alu_out <= alu;
        rd_out <= rd;
      end
      if (load_rd) rdata_out <= rdata;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: branch resolve, stalling data-memory access with timeout, and MEM/WB register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WBW-1:0]  WB,
  input  logic            Branch,
  input  logic            MemWrite,
  input  logic            MemRead,
  input  logic [XLEN-1:0] Adder_Result,
  input  logic            ALU_Zero,
  input  logic [XLEN-1:0] ALU_Result,
  input  logic [XLEN-1:0] Forward_B_Mux_Result,
  input  logic [REGW-1:0] ID_EX_Rd,
  mem_wb_stage_if.master  dmem,
  output logic            PCSrc,
  output logic [XLEN-1:0] Branch_Target,
  output logic            Stall,
  output logic            Mem_Error,
  output logic [WBW-1:0]  WB_Out,
  output logic [XLEN-1:0] Read_Data_Out,
  output logic [XLEN-1:0] ALU_Result_Out,
  output logic [REGW-1:0] Rd_Out
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic mem_op, misaligned, done, abort, load, load_rd, err_nx;
  assign PCSrc = Branch & ALU_Zero;
  assign Branch_Target = Adder_Result;
  assign mem_op = MemRead | MemWrite;
  assign misaligned = mem_op & |ALU_Result[2:0];
  assign dmem.we = MemWrite;
  assign dmem.addr = ALU_Result;
  assign dmem.wdata = Forward_B_Mux_Result;
  // reset gates req so a held EX/MEM mem op cannot re-raise it while reset is asserted
  always_comb begin
    dmem.req = reset & ((state == WAIT) | (mem_op & ~misaligned));
    done = dmem.req & dmem.ready;
    abort = (state == WAIT) & ~dmem.ready & (cnt == CW'(TIMEOUT));
    Stall = dmem.req & ~dmem.ready & ~abort;
    state_nx = Stall ? WAIT : IDLE;
    cnt_nx = Stall ? cnt + 1'b1 : '0;
    load = ((state == IDLE) & ~mem_op) | done;
    load_rd = done & ~MemWrite;
    err_nx = ((state == IDLE) & misaligned) | abort;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      Mem_Error <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      Mem_Error <= err_nx;
    end
  mem_wb_reg u_reg (
    .clk(clk), .reset(reset), .load(load), .load_rd(load_rd),
    .wb(WB), .alu(ALU_Result), .rdata(dmem.rdata), .rd(ID_EX_Rd),
    .wb_out(WB_Out), .alu_out(ALU_Result_Out), .rdata_out(Read_Data_Out), .rd_out(Rd_Out)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage with TIMEOUT=4.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [WBW-1:0] WB = '0;
  logic Branch = 1'b0, MemWrite = 1'b0, MemRead = 1'b0, ALU_Zero = 1'b0;
  logic [XLEN-1:0] Adder_Result = '0, ALU_Result = '0, Forward_B_Mux_Result = '0;
  logic [REGW-1:0] ID_EX_Rd = '0;
  logic PCSrc, Stall, Mem_Error;
  logic [XLEN-1:0] Branch_Target, Read_Data_Out, ALU_Result_Out;
  logic [WBW-1:0] WB_Out;
  logic [REGW-1:0] Rd_Out;
  int errors = 0;
  int checks = 0;
  mem_wb_stage_if dmem_if ();
  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .WB(WB), .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead),
    .Adder_Result(Adder_Result), .ALU_Zero(ALU_Zero), .ALU_Result(ALU_Result),
    .Forward_B_Mux_Result(Forward_B_Mux_Result), .ID_EX_Rd(ID_EX_Rd), .dmem(dmem_if),
    .PCSrc(PCSrc), .Branch_Target(Branch_Target), .Stall(Stall), .Mem_Error(Mem_Error),
    .WB_Out(WB_Out), .Read_Data_Out(Read_Data_Out), .ALU_Result_Out(ALU_Result_Out), .Rd_Out(Rd_Out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    MemRead = 0; MemWrite = 0; Branch = 0; ALU_Zero = 0; dmem_if.ready = 0;
  endtask
  initial begin
    dmem_if.ready = 0;
    dmem_if.rdata = '0;
    #2;
    chk("rst_wb", WB_Out, 0);
    chk("rst_rdata", Read_Data_Out, 0);
    chk("rst_alu", ALU_Result_Out, 0);
    chk("rst_rd", Rd_Out, 0);
    chk("rst_err", Mem_Error, 0);
    chk("rst_req", dmem_if.req, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    WB = 2'b10; ALU_Result = 64'h2A; ID_EX_Rd = 5;
    #1;
    chk("rtype_stall", Stall, 0);
    chk("rtype_req", dmem_if.req, 0);
    tick();
    chk("rtype_wb", WB_Out, 2'b10);
    chk("rtype_alu", ALU_Result_Out, 64'h2A);
    chk("rtype_rd", Rd_Out, 5);
    MemRead = 1; ALU_Result = 64'h100; WB = 2'b11; ID_EX_Rd = 7;
    dmem_if.ready = 1; dmem_if.rdata = 64'hDEADBEEF;
    #1;
    chk("ld0_req", dmem_if.req, 1);
    chk("ld0_we", dmem_if.we, 0);
    chk("ld0_addr", dmem_if.addr, 64'h100);
    chk("ld0_stall", Stall, 0);
    tick();
    chk("ld0_rdata", Read_Data_Out, 64'hDEADBEEF);
    chk("ld0_wb", WB_Out, 2'b11);
    chk("ld0_rd", Rd_Out, 7);
    idle();
    dmem_if.rdata = 64'h1234;
    #1;
    chk("ld0_req_drop", dmem_if.req, 0);
    MemWrite = 1; ALU_Result = 64'h08; Forward_B_Mux_Result = 64'h55; WB = 2'b10; ID_EX_Rd = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st3_stall", Stall, 1);
      chk("st3_req", dmem_if.req, 1);
      chk("st3_we", dmem_if.we, 1);
      chk("st3_wdata", dmem_if.wdata, 64'h55);
      tick();
      chk("st3_bubble", WB_Out, 0);
      chk("st3_alu_hold", ALU_Result_Out, 64'h100);
    end
    dmem_if.ready = 1;
    #1;
    chk("st3_done_stall", Stall, 0);
    chk("st3_done_we", dmem_if.we, 1);
    tick();
    chk("st3_wb", WB_Out, 2'b10);
    chk("st3_alu", ALU_Result_Out, 64'h08);
    chk("st3_rd", Rd_Out, 3);
    chk("st3_rdata_hold", Read_Data_Out, 64'hDEADBEEF);
    idle();
    MemRead = 1; ALU_Result = 64'h200; WB = 2'b11; ID_EX_Rd = 9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", Stall, 1);
      tick();
      chk("to_bubble", WB_Out, 0);
      chk("to_err_low", Mem_Error, 0);
    end
    #1;
    chk("to_abort_stall", Stall, 0);
    chk("to_abort_req", dmem_if.req, 1);
    tick();
    chk("to_err", Mem_Error, 1);
    chk("to_wb", WB_Out, 0);
    chk("to_rdata_hold", Read_Data_Out, 64'hDEADBEEF);
    idle();
    WB = 2'b00;
    #1;
    chk("to_req_drop", dmem_if.req, 0);
    tick();
    chk("to_err_pulse", Mem_Error, 0);
    MemRead = 1; ALU_Result = 64'h103; WB = 2'b11; ID_EX_Rd = 12;
    dmem_if.ready = 1;
    #1;
    chk("mis_req", dmem_if.req, 0);
    chk("mis_stall", Stall, 0);
    tick();
    chk("mis_err", Mem_Error, 1);
    chk("mis_wb", WB_Out, 0);
    chk("mis_rdata_hold", Read_Data_Out, 64'hDEADBEEF);
    idle();
    tick();
    chk("mis_err_pulse", Mem_Error, 0);
    Branch = 1; ALU_Zero = 1; Adder_Result = 64'h40;
    #1;
    chk("br_pcsrc", PCSrc, 1);
    chk("br_target", Branch_Target, 64'h40);
    ALU_Zero = 0;
    #1;
    chk("br_nottaken", PCSrc, 0);
    idle();
    MemRead = 1; ALU_Result = 64'h300; WB = 2'b11; ID_EX_Rd = 4;
    tick();
    chk("rw_stall", Stall, 1);
    chk("rw_req", dmem_if.req, 1);
    #2;
    reset = 0;
    #1;
    chk("rw_req_clr", dmem_if.req, 0);
    chk("rw_stall_clr", Stall, 0);
    chk("rw_wb_clr", WB_Out, 0);
    chk("rw_alu_clr", ALU_Result_Out, 0);
    chk("rw_rdata_clr", Read_Data_Out, 0);
    #1;
    reset = 1;
    idle();
    WB = 2'b01; ALU_Result = 64'h77; ID_EX_Rd = 31;
    tick();
    chk("post_wb", WB_Out, 2'b01);
    chk("post_alu", ALU_Result_Out, 64'h77);
    chk("post_rd", Rd_Out, 31);
    chk("post_err", Mem_Error, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
